// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, FSM states, datapath select codes.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Used by the control unit, its decoder, the immediate extender and the ALU.
package mcpu_pkg;

   // Opcodes, IR[31:26]
   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDI  = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b010000;
   localparam logic [5:0] OP_AND   = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTIU = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   // The eight working states use every 3-bit code, so HALT lives in a
   // fourth bit. Only the low three bits are exported for debug.
   typedef enum logic [3:0] {
      ST_IF     = 4'b0000,
      ST_ID     = 4'b0001,
      ST_EXE_LS = 4'b0010,
      ST_MEM    = 4'b0011,
      ST_WB_LD  = 4'b0100,
      ST_EXE_BR = 4'b0101,
      ST_EXE_AL = 4'b0110,
      ST_WB_AL  = 4'b0111,
      ST_HALT   = 4'b1000
   } state_t;

   // ALU operations
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_SLL  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_SLTU = 3'b101;
   localparam logic [2:0] ALU_SLT  = 3'b110;

   // Immediate extender modes
   localparam logic [1:0] EXT_SHAMT = 2'd0;
   localparam logic [1:0] EXT_ZERO  = 2'd1;
   localparam logic [1:0] EXT_SIGN  = 2'd2;

   // Next-PC sources
   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_REG    = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   // Register-file write destinations
   localparam logic [1:0] DST_RA = 2'b00;
   localparam logic [1:0] DST_RT = 2'b01;
   localparam logic [1:0] DST_RD = 2'b10;

   // Instructions that go through EXE_AL / WB_AL
   function automatic logic isAlu(input logic [5:0] op);
      return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
                        OP_ORI, OP_SLL, OP_SLT, OP_SLTIU};
   endfunction

   function automatic logic isKnown(input logic [5:0] op);
      return isAlu(op) || (op inside {OP_SW, OP_LW, OP_BEQ, OP_BLTZ,
                                      OP_J, OP_JR, OP_JAL, OP_HALT});
   endfunction

endpackage

// File: rtl/mcu_decode.sv
// Combinational control decode: (state, opcode, ALU flags) -> every datapath control.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; no handshake.
// Ports: Reset forces all controls low; state/Opcode/Zero/Sign in; PC, memory,
// IR, register-file, extender, ALU and write-back controls out.
module mcu_decode
   import mcpu_pkg::*;
#(
   parameter bit ILLEGAL_AS_HALT = 1'b0
) (
   input  logic       Reset,
   input  state_t     state,
   input  logic [5:0] Opcode,
   input  logic       Zero,
   input  logic       Sign,
   output logic       PCWre,
   output logic       InsMemRW,
   output logic       IRWre,
   output logic [1:0] ExtSel,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       mRD,
   output logic       mWR,
   output logic       DBDataSrc,
   output logic       RegWre,
   output logic       WrRegDSrc,
   output logic [1:0] RegDst,
   output logic [1:0] PCSrc
);

   // Per-instruction datapath selects. These are held constant from ID to the
   // instruction's last state so the extender/ALU/write-back path never glitches.
   logic [1:0] opExtSel;
   logic [2:0] opAluOp;
   logic       opSrcA;
   logic       opSrcB;
   logic [1:0] opRegDst;
   logic       opLoad;

   always_comb begin
      opExtSel = EXT_SIGN;
      opAluOp  = ALU_ADD;
      opSrcA   = 1'b0;
      opSrcB   = 1'b0;
      opRegDst = DST_RA;
      opLoad   = 1'b0;
      case (Opcode)
         OP_ADD:   opRegDst = DST_RD;
         OP_SUB:   begin opAluOp = ALU_SUB; opRegDst = DST_RD; end
         OP_ADDI:  begin opSrcB = 1'b1; opRegDst = DST_RT; end
         OP_OR:    begin opAluOp = ALU_OR; opRegDst = DST_RD; end
         OP_AND:   begin opAluOp = ALU_AND; opRegDst = DST_RD; end
         OP_ORI:   begin opAluOp = ALU_OR; opSrcB = 1'b1; opRegDst = DST_RT; opExtSel = EXT_ZERO; end
         OP_SLL:   begin opAluOp = ALU_SLL; opSrcA = 1'b1; opRegDst = DST_RD; opExtSel = EXT_SHAMT; end
         OP_SLT:   begin opAluOp = ALU_SLT; opRegDst = DST_RD; end
         OP_SLTIU: begin opAluOp = ALU_SLTU; opSrcB = 1'b1; opRegDst = DST_RT; opExtSel = EXT_ZERO; end
         OP_SW:    opSrcB = 1'b1;
         OP_LW:    begin opSrcB = 1'b1; opRegDst = DST_RT; opLoad = 1'b1; end
         OP_BEQ,
         OP_BLTZ:  opAluOp = ALU_SUB;   // bltz computes rs-0 and tests the sign
         default:  ;
      endcase
   end

   always_comb begin
      PCWre     = 1'b0;
      InsMemRW  = 1'b0;
      IRWre     = 1'b0;
      ExtSel    = 2'd0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'd0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;
      RegWre    = 1'b0;
      WrRegDSrc = 1'b0;
      RegDst    = 2'd0;
      PCSrc     = PC_NEXT;
      if (!Reset) begin
         case (state)
            ST_IF:   begin InsMemRW = 1'b1; IRWre = 1'b1; end
            ST_HALT: ;
            default: begin
               ExtSel    = opExtSel;
               ALUOp     = opAluOp;
               ALUSrcA   = opSrcA;
               ALUSrcB   = opSrcB;
               RegDst    = opRegDst;
               DBDataSrc = opLoad;
               WrRegDSrc = 1'b1;
               case (state)
                  ST_ID: begin
                     case (Opcode)
                        OP_J:    begin PCWre = 1'b1; PCSrc = PC_JUMP; end
                        OP_JAL:  begin PCWre = 1'b1; PCSrc = PC_JUMP; RegWre = 1'b1; WrRegDSrc = 1'b0; end
                        OP_JR:   begin PCWre = 1'b1; PCSrc = PC_REG; end
                        // unknown opcode retires here as a NOP unless it halts
                        default: PCWre = !isKnown(Opcode) && !ILLEGAL_AS_HALT;
                     endcase
                  end
                  ST_EXE_BR: begin
                     PCWre = 1'b1;
                     if ((Opcode == OP_BEQ && Zero) || (Opcode == OP_BLTZ && Sign))
                        PCSrc = PC_BRANCH;
                  end
                  ST_MEM: begin
                     if (Opcode == OP_LW) begin
                        mRD = 1'b1;
                     end else begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                     end
                  end
                  ST_WB_AL: begin PCWre = 1'b1; RegWre = 1'b1; end
                  ST_WB_LD: begin PCWre = 1'b1; RegWre = 1'b1; mRD = 1'b1; end
                  default:  ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU sequencer: walks each instruction through IF/ID/EXE/MEM/WB.
// Latency: jumps 2 cycles, branch 3, ALU 4, sw 4, lw 5; HALT holds until Reset.
// Backpressure: none; advances every clock.
// Ports: CLK, Reset (sync, active-high), Opcode/Zero/Sign in; datapath controls
// out via mcu_decode; State is a debug view (HALT reads as 000 with InsMemRW=0).
module multicycle_control_unit
   import mcpu_pkg::*;
#(
   parameter bit ILLEGAL_AS_HALT = 1'b0
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic       Zero,
   input  logic       Sign,
   output logic       PCWre,
   output logic       InsMemRW,
   output logic       IRWre,
   output logic [1:0] ExtSel,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       mRD,
   output logic       mWR,
   output logic       DBDataSrc,
   output logic       RegWre,
   output logic       WrRegDSrc,
   output logic [1:0] RegDst,
   output logic [1:0] PCSrc,
   output logic [2:0] State
);

   state_t state;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= ST_IF;
      end else begin
         case (state)
            ST_IF: state <= ST_ID;
            ST_ID: begin
               if (Opcode inside {OP_J, OP_JAL, OP_JR})   state <= ST_IF;
               else if (Opcode == OP_HALT)                state <= ST_HALT;
               else if (Opcode inside {OP_BEQ, OP_BLTZ})  state <= ST_EXE_BR;
               else if (Opcode inside {OP_LW, OP_SW})     state <= ST_EXE_LS;
               else if (isAlu(Opcode))                    state <= ST_EXE_AL;
               else                                       state <= ILLEGAL_AS_HALT ? ST_HALT : ST_IF;
            end
            ST_EXE_AL: state <= ST_WB_AL;
            ST_WB_AL:  state <= ST_IF;
            ST_EXE_BR: state <= ST_IF;
            ST_EXE_LS: state <= ST_MEM;
            ST_MEM:    state <= (Opcode == OP_LW) ? ST_WB_LD : ST_IF;
            ST_WB_LD:  state <= ST_IF;
            ST_HALT:   state <= ST_HALT;
            default:   state <= ST_IF;
         endcase
      end
   end

   assign State = Reset ? 3'b000 : state[2:0];

   mcu_decode #(
      .ILLEGAL_AS_HALT(ILLEGAL_AS_HALT)
   ) u_decode (
      .Reset     (Reset),
      .state     (state),
      .Opcode    (Opcode),
      .Zero      (Zero),
      .Sign      (Sign),
      .PCWre     (PCWre),
      .InsMemRW  (InsMemRW),
      .IRWre     (IRWre),
      .ExtSel    (ExtSel),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .mRD       (mRD),
      .mWR       (mWR),
      .DBDataSrc (DBDataSrc),
      .RegWre    (RegWre),
      .WrRegDSrc (WrRegDSrc),
      .RegDst    (RegDst),
      .PCSrc     (PCSrc)
   );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed instructions, then a random instruction
// stream, halt hold and reset-abort, each cycle compared with an instruction-level model.
// Latency/backpressure: n/a.
module tb_multicycle_control_unit;

   localparam logic [5:0] opAdd   = 6'b000000;
   localparam logic [5:0] opSub   = 6'b000001;
   localparam logic [5:0] opAddi  = 6'b000010;
   localparam logic [5:0] opOr    = 6'b010000;
   localparam logic [5:0] opAnd   = 6'b010001;
   localparam logic [5:0] opOri   = 6'b010010;
   localparam logic [5:0] opSll   = 6'b011000;
   localparam logic [5:0] opSlt   = 6'b100110;
   localparam logic [5:0] opSltiu = 6'b100111;
   localparam logic [5:0] opSw    = 6'b110000;
   localparam logic [5:0] opLw    = 6'b110001;
   localparam logic [5:0] opBeq   = 6'b110100;
   localparam logic [5:0] opBltz  = 6'b110110;
   localparam logic [5:0] opJ     = 6'b111000;
   localparam logic [5:0] opJr    = 6'b111001;
   localparam logic [5:0] opJal   = 6'b111010;
   localparam logic [5:0] opHalt  = 6'b111111;

   logic       CLK;
   logic       Reset;
   logic [5:0] Opcode;
   logic       Zero;
   logic       Sign;
   logic       PCWre, InsMemRW, IRWre, ALUSrcA, ALUSrcB;
   logic       mRD, mWR, DBDataSrc, RegWre, WrRegDSrc;
   logic [1:0] ExtSel, RegDst, PCSrc;
   logic [2:0] ALUOp, State;

   int nAsserts = 0;
   int nFails   = 0;

   logic [5:0] pool [19] = '{opAdd, opSub, opAddi, opOr, opAnd, opOri, opSll, opSlt,
                             opSltiu, opSw, opLw, opBeq, opBltz, opJ, opJr, opJal,
                             6'b000011, 6'b101010, 6'b011111};

   multicycle_control_unit dut (
      .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .Sign(Sign),
      .PCWre(PCWre), .InsMemRW(InsMemRW), .IRWre(IRWre), .ExtSel(ExtSel),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
      .DBDataSrc(DBDataSrc), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
      .RegDst(RegDst), .PCSrc(PCSrc), .State(State)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   wire [18:0] allOut = {PCWre, InsMemRW, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
                         mRD, mWR, DBDataSrc, RegWre, WrRegDSrc, RegDst, PCSrc};
   wire [15:0] otherThanFetch = {ExtSel, ALUSrcA, ALUSrcB, ALUOp, mRD, mWR,
                                 DBDataSrc, RegWre, WrRegDSrc, RegDst, PCSrc, PCWre};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---- instruction-level reference model ----
   function automatic bit isAluCls(input logic [5:0] op);
      return op inside {opAdd, opSub, opAddi, opOr, opAnd, opOri, opSll, opSlt, opSltiu};
   endfunction

   function automatic bit isImm(input logic [5:0] op);
      return op inside {opAddi, opOri, opSltiu, opLw, opSw};
   endfunction

   // cycles an instruction takes; unknown opcodes retire as 2-cycle NOPs
   function automatic int instLen(input logic [5:0] op);
      if (op inside {opBeq, opBltz}) return 3;
      if (op == opSw)                return 4;
      if (op == opLw)                return 5;
      if (isAluCls(op))              return 4;
      return 2;
   endfunction

   function automatic logic [2:0] stateAt(input logic [5:0] op, input int phase);
      case (phase)
         0: return 3'b000;
         1: return 3'b001;
         2: return (op inside {opBeq, opBltz}) ? 3'b101 :
                   (op inside {opLw, opSw})    ? 3'b010 : 3'b110;
         3: return (op inside {opLw, opSw}) ? 3'b011 : 3'b111;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [1:0] expExt(input logic [5:0] op);
      if (op == opSll) return 2'd0;
      if (op inside {opOri, opSltiu}) return 2'd1;
      return 2'd2;
   endfunction

   function automatic logic [2:0] expAlu(input logic [5:0] op);
      case (op)
         opSub, opBeq, opBltz: return 3'b001;
         opSll:                return 3'b010;
         opOr, opOri:          return 3'b011;
         opAnd:                return 3'b100;
         opSltiu:              return 3'b101;
         opSlt:                return 3'b110;
         default:              return 3'b000;
      endcase
   endfunction

   task automatic checkPhase(input logic [5:0] op, input int phase);
      int len = instLen(op);
      bit last = (phase == len - 1);
      bit writes = isAluCls(op) || op == opLw || op == opJal;
      logic [1:0] pcs = 2'b00;
      if (phase == 1 && op inside {opJ, opJal}) pcs = 2'b11;
      if (phase == 1 && op == opJr) pcs = 2'b10;
      if (phase == 2 && ((op == opBeq && Zero) || (op == opBltz && Sign))) pcs = 2'b01;
      chk("State",    32'(State),    32'(stateAt(op, phase)));
      chk("PCWre",    32'(PCWre),    32'(last));
      chk("InsMemRW", 32'(InsMemRW), 32'(phase == 0));
      chk("IRWre",    32'(IRWre),    32'(phase == 0));
      chk("RegWre",   32'(RegWre),   32'(writes && last));
      chk("mRD",      32'(mRD),      32'(op == opLw && phase >= 3));
      chk("mWR",      32'(mWR),      32'(op == opSw && phase == 3));
      chk("PCSrc",    32'(PCSrc),    32'(pcs));
      if (phase == 0) begin
         chk("ifQuiet", 32'(otherThanFetch), 32'd0);
      end else begin
         chk("ExtSel", 32'(ExtSel), 32'(expExt(op)));
      end
      if (phase == 2) begin
         chk("ALUOp",   32'(ALUOp),   32'(expAlu(op)));
         chk("ALUSrcA", 32'(ALUSrcA), 32'(op == opSll));
         chk("ALUSrcB", 32'(ALUSrcB), 32'(isImm(op)));
      end
      if (writes && last) begin
         chk("RegDst",    32'(RegDst),    (op == opJal) ? 32'd0 : (isImm(op) ? 32'd1 : 32'd2));
         chk("WrRegDSrc", 32'(WrRegDSrc), 32'(op != opJal));
         chk("DBDataSrc", 32'(DBDataSrc), 32'(op == opLw));
      end
   endtask

   // Entered at posedge+1 with the DUT in IF; leaves at posedge+1 back in IF.
   task automatic runInst(input logic [5:0] op, input bit rnd, input bit z, input bit s);
      Opcode = op;
      for (int p = 0; p < instLen(op); p++) begin
         if (rnd) begin
            Zero = 1'($urandom_range(0, 1));
            Sign = 1'($urandom_range(0, 1));
         end else begin
            Zero = z;
            Sign = s;
         end
         #3;
         checkPhase(op, p);
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      Reset = 1'b1; Opcode = opAdd; Zero = 1'b0; Sign = 1'b0;
      @(posedge CLK); #1;
      for (int i = 0; i < 3; i++) begin
         Opcode = pool[i * 5];
         #3;
         chk("resetOut",   32'(allOut), 32'd0);
         chk("resetState", 32'(State),  32'd0);
         @(posedge CLK); #1;
      end
      Reset = 1'b0;

      // directed instructions
      runInst(opAdd,   1'b0, 1'b0, 1'b0);
      runInst(opLw,    1'b1, 1'b0, 1'b0);
      runInst(opSw,    1'b1, 1'b0, 1'b0);
      runInst(opBeq,   1'b0, 1'b1, 1'b0);
      runInst(opBeq,   1'b0, 1'b0, 1'b1);
      runInst(opBltz,  1'b0, 1'b0, 1'b1);
      runInst(opBltz,  1'b0, 1'b1, 1'b0);
      runInst(opJal,   1'b1, 1'b0, 1'b0);
      runInst(opJr,    1'b1, 1'b0, 1'b0);
      runInst(opJ,     1'b1, 1'b0, 1'b0);
      runInst(opOri,   1'b1, 1'b0, 1'b0);
      runInst(opSll,   1'b1, 1'b0, 1'b0);
      runInst(opSltiu, 1'b1, 1'b0, 1'b0);
      runInst(6'b101010, 1'b1, 1'b0, 1'b0);

      // random instruction stream, including unknown opcodes
      for (int i = 0; i < 150; i++)
         runInst(pool[$urandom_range(0, 18)], 1'b1, 1'b0, 1'b0);

      // halt: IF, ID, then parked with no PC or state updates
      Opcode = opHalt;
      #3;
      chk("haltIF", 32'(State), 32'd0);
      @(posedge CLK); #1;
      #3;
      chk("haltIDState", 32'(State), 32'd1);
      chk("haltIDPCWre", 32'(PCWre), 32'd0);
      @(posedge CLK); #1;
      for (int i = 0; i < 20; i++) begin
         Zero = 1'($urandom_range(0, 1));
         #3;
         chk("haltPCWre",  32'(PCWre),  32'd0);
         chk("haltRegWre", 32'(RegWre), 32'd0);
         chk("haltMWR",    32'(mWR),    32'd0);
         chk("haltIRWre",  32'(IRWre),  32'd0);
         @(posedge CLK); #1;
      end
      Reset = 1'b1;
      @(posedge CLK); #1;
      Reset = 1'b0;
      runInst(opAdd, 1'b1, 1'b0, 1'b0);

      // reset during EXE_LS of sw aborts it before any memory write
      Opcode = opSw;
      #3;
      chk("swIF", 32'(State), 32'd0);
      @(posedge CLK); #1;
      #3;
      chk("swID", 32'(State), 32'd1);
      @(posedge CLK); #1;
      #1;
      chk("swExeLs", 32'(State), 32'd2);
      Reset = 1'b1;
      #2;
      chk("abortOut",   32'(allOut), 32'd0);
      chk("abortState", 32'(State),  32'd0);
      chk("abortMWR",   32'(mWR),    32'd0);
      @(posedge CLK); #1;
      Reset = 1'b0;
      runInst(opAdd, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
